regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised general-purpose register file with hazard scoreboard and soft-clear sweep, the next-generation register bank of the processor datapath. Provides two combinational read ports, one clocked write port with optional write-to-read bypass, an optional hardwired-zero register 0, and per-register busy bits that the issue stage reserves and the writeback port releases. A sequential clear engine zeroes the whole bank on request, one register per cycle, without asserting reset.

## Interface
Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers (≥2, need not be a power of two).
- AW, $clog2(DEPTH), address width.
- ZERO_REG, 1: register 0 reads 0 and ignores writes and reserves.
- BYPASS, 1: same-cycle write data is forwarded to matching read ports.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- R1  in  AW  read address, port A.
- R2  in  AW  read address, port B.
- A  out  DW  read data, port A.
- B  out  DW  read data, port B.
- A_busy  out  1  register R1 has a pending producer.
- B_busy  out  1  register R2 has a pending producer.
- W  in  1  write enable.
- WAd  in  AW  write address.
- Data  in  DW  write data.
- Rsv  in  1  reserve enable (set busy bit).
- RsvAd  in  AW  reserve address.
- Clr  in  1  start a clear sweep (level-sampled).
- Ready  out  1  high in IDLE; W, Rsv and Clr accepted only while high.

## Operation
- State: DEPTH×DW storage, DEPTH busy bits, FSM {IDLE, CLEAR}, sweep counter cnt (AW bits).
- Read (combinational): A = 0 if R1 ≥ DEPTH or (ZERO_REG and R1==0); else Data if BYPASS, W, Ready and WAd==R1; else mem[R1]. B identical on R2.
- A_busy = busy[R1], forced 0 on a bypass hit or when R1 is zero-reg/out-of-range. B_busy likewise.
- Write: at rising edge with W && Ready, mem[WAd] <= Data, busy[WAd] <= 0. Ignored for WAd ≥ DEPTH or (ZERO_REG and WAd==0).
- Reserve: at rising edge with Rsv && Ready, busy[RsvAd] <= 1; same exclusions as write.
- Same-edge write and reserve to one address: data written, busy ends 1 (reserve wins; new producer).
- Clr && Ready at an edge: IDLE→CLEAR, cnt <= 0. A write/reserve on that same edge is still performed.
- CLEAR: each edge mem[cnt] <= 0, busy[cnt] <= 0, cnt++. On the edge clearing cnt==DEPTH-1: →IDLE, cnt <= 0.
- In CLEAR: W, Rsv, Clr ignored; reads return current (partially cleared) contents, no bypass.

## Timing
- Reset (Rst_n low, immediate): all mem = 0, all busy = 0, state IDLE, cnt = 0, Ready = 1; A/B = 0, A_busy/B_busy = 0.
- Reset mid-sweep: aborts immediately, same values as above.
- Read latency 0 (combinational from address/storage); write visible on the same-cycle read only via BYPASS, otherwise from the next cycle.
- Clr sampled at edge k: Ready low after edge k; registers 0..DEPTH-1 cleared on edges k+1..k+DEPTH; Ready high after edge k+DEPTH. Sweep = DEPTH cycles of unavailability.
- Ready is a registered output (function of state only); no combinational path from inputs to Ready.

## Structure
- Package regfile_pkg: state enum (IDLE, CLEAR), default DW/DEPTH constants.
- Optional sub-module regfile_sweep: FSM + cnt, outputs Ready, clr_en, clr_addr. Storage, busy bits and read muxing stay in regfile_sb.

## Test plan
- Reset then read all 32 addresses -> A=B=0, busy 0, Ready=1.
- Write 0xDEADBEEF to r5 with R1=5 same cycle -> A=0xDEADBEEF (BYPASS=1); next cycle with W=0 still 0xDEADBEEF; write to r0 -> r0 reads 0.
- Rsv r7, next cycle R2=7 -> B_busy=1; write r7=3 -> B_busy 0 in bypass cycle and after; same-edge Rsv+W to r7 -> B_busy=1, B=new data.
- Fill r1..r31 with index, pulse Clr -> Ready low for exactly 32 cycles, r10 reads 10 until edge k+11 then 0; W asserted during sweep has no effect.
- Assert Rst_n low at sweep cycle 15 -> Ready=1 and all registers 0 immediately.
- DEPTH=20 instance: write/read address 25 -> write ignored, read returns 0; sweep lasts 20 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register file with hazard scoreboard.
// The sweep state names are the ones used by regfile_sweep.
package regfile_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/regfile_sweep.sv
// Soft-clear sequencer: walks every register index once per sweep.
// While it runs, the bank is unavailable to writes and reserves.
//
// state | meaning
// IDLE  | bank available, Ready high, waiting for start
// CLEAR | zeroing register clr_addr on every edge, Ready low
module regfile_sweep
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          ready,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  sweep_state_e  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Ready depends on the state register only, so it never sees input glitches.
  assign ready    = (state_q == IDLE);
  assign clr_en   = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with per-register busy scoreboard, optional
// write-to-read bypass, optional hardwired-zero r0 and a sequential soft clear.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [AW-1:0] R1,
  input  logic [AW-1:0] R2,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          A_busy,
  output logic          B_busy,
  input  logic          W,
  input  logic [AW-1:0] WAd,
  input  logic [DW-1:0] Data,
  input  logic          Rsv,
  input  logic [AW-1:0] RsvAd,
  input  logic          Clr,
  output logic          Ready
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;

  logic          ready;
  logic          clr_en;
  logic [AW-1:0] clr_addr;

  logic a_ok, b_ok, a_hit, b_hit;

  // Out-of-range indices (non power-of-two DEPTH) and the zero register are
  // never stored, reserved or read.
  function automatic logic addr_ok(input logic [AW-1:0] ad);
    addr_ok = (int'(ad) < DEPTH) && !(ZERO_REG && (ad == '0));
  endfunction

  regfile_sweep #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sweep (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .start    (Clr),
    .ready    (ready),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign Ready = ready;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mem_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Reserve is applied after the write so a same-edge pair leaves the
  // register owned by the new producer.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (clr_en) begin
      mem_d[clr_addr]  = '0;
      busy_d[clr_addr] = 1'b0;
    end else begin
      if (W && ready && addr_ok(WAd)) begin
        mem_d[WAd]  = Data;
        busy_d[WAd] = 1'b0;
      end
      if (Rsv && ready && addr_ok(RsvAd)) begin
        busy_d[RsvAd] = 1'b1;
      end
    end
  end

  always_comb begin
    a_ok  = addr_ok(R1);
    b_ok  = addr_ok(R2);
    a_hit = BYPASS && W && ready && (WAd == R1);
    b_hit = BYPASS && W && ready && (WAd == R2);

    A      = '0;
    A_busy = 1'b0;
    if (a_ok) begin
      if (a_hit) begin
        A = Data;
      end else begin
        A      = mem_q[R1];
        A_busy = busy_q[R1];
      end
    end

    B      = '0;
    B_busy = 1'b0;
    if (b_ok) begin
      if (b_hit) begin
        B = Data;
      end else begin
        B      = mem_q[R2];
        B_busy = busy_q[R2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, sweep/reset sequences, random
// traffic against an array-based model, and a DEPTH=20 instance.
module tb_regfile_sb;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [4:0]  R1, R2, WAd, RsvAd;
  logic [31:0] Data;
  logic        W, Rsv, Clr;
  logic [31:0] A, B;
  logic        A_busy, B_busy, Ready;

  logic [4:0]  s_R1, s_R2, s_WAd, s_RsvAd;
  logic [31:0] s_Data;
  logic        s_W, s_Rsv, s_Clr;
  logic [31:0] s_A, s_B;
  logic        s_A_busy, s_B_busy, s_Ready;

  always #5 Clk = ~Clk;

  regfile_sb #(.DW(32), .DEPTH(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .R1(R1), .R2(R2), .A(A), .B(B),
    .A_busy(A_busy), .B_busy(B_busy), .W(W), .WAd(WAd), .Data(Data),
    .Rsv(Rsv), .RsvAd(RsvAd), .Clr(Clr), .Ready(Ready)
  );

  regfile_sb #(.DW(32), .DEPTH(20)) dut20 (
    .Clk(Clk), .Rst_n(Rst_n), .R1(s_R1), .R2(s_R2), .A(s_A), .B(s_B),
    .A_busy(s_A_busy), .B_busy(s_B_busy), .W(s_W), .WAd(s_WAd), .Data(s_Data),
    .Rsv(s_Rsv), .RsvAd(s_RsvAd), .Clr(s_Clr), .Ready(s_Ready)
  );

  int tests = 0;
  int fails = 0;

  // Reference model of the 32-entry instance
  logic [31:0] m_mem [32];
  bit          m_busy[32];
  bit          m_sweep;
  int          m_pos;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_sweep = 1'b0;
    m_pos   = 0;
  endfunction

  function automatic bit valid(int a);
    return (a < 32) && (a != 0);
  endfunction

  function automatic void model_edge();
    if (m_sweep) begin
      m_mem[m_pos]  = '0;
      m_busy[m_pos] = 1'b0;
      m_pos++;
      if (m_pos == 32) begin
        m_sweep = 1'b0;
        m_pos   = 0;
      end
    end else begin
      if (W && valid(int'(WAd))) begin
        m_mem[WAd]  = Data;
        m_busy[WAd] = 1'b0;
      end
      if (Rsv && valid(int'(RsvAd))) m_busy[RsvAd] = 1'b1;
      if (Clr) begin
        m_sweep = 1'b1;
        m_pos   = 0;
      end
    end
  endfunction

  function automatic logic [31:0] exp_rd(int a);
    if (!valid(a)) return '0;
    if (!m_sweep && W && int'(WAd) == a) return Data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(int a);
    if (!valid(a)) return 1'b0;
    if (!m_sweep && W && int'(WAd) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic check_model(string tag);
    cmp({tag, ".A"}, A, exp_rd(int'(R1)));
    cmp({tag, ".B"}, B, exp_rd(int'(R2)));
    cmp({tag, ".A_busy"}, 32'(A_busy), 32'(exp_busy(int'(R1))));
    cmp({tag, ".B_busy"}, 32'(B_busy), 32'(exp_busy(int'(R2))));
    cmp({tag, ".Ready"}, 32'(Ready), 32'(!m_sweep));
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit          w;
    logic [4:0]  wad;
    logic [31:0] data;
    bit          rsv;
    logic [4:0]  rsvad;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] ea;
    logic [31:0] eb;
    bit          eab;
    bit          ebb;
  } vec_t;

  function automatic vec_t mk(bit w, int wad, logic [31:0] data, bit rsv, int rsvad,
                              int r1, int r2, logic [31:0] ea, logic [31:0] eb,
                              bit eab, bit ebb);
    vec_t v;
    v.w = w; v.wad = 5'(wad); v.data = data; v.rsv = rsv; v.rsvad = 5'(rsvad);
    v.r1 = 5'(r1); v.r2 = 5'(r2); v.ea = ea; v.eb = eb; v.eab = eab; v.ebb = ebb;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[11];
    int   n;

    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vecs[2]  = mk(1, 0, 32'h1234,     0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,        1, 7, 0, 7, 32'h0, 32'h0, 0, 0);
    vecs[4]  = mk(0, 0, 32'h0,        0, 0, 5, 7, 32'hDEADBEEF, 32'h0, 0, 1);
    vecs[5]  = mk(1, 7, 32'h3,        0, 0, 7, 7, 32'h3, 32'h3, 0, 0);
    vecs[6]  = mk(0, 0, 32'h0,        0, 0, 7, 7, 32'h3, 32'h3, 0, 0);
    vecs[7]  = mk(1, 7, 32'd99,       1, 7, 5, 7, 32'hDEADBEEF, 32'd99, 0, 0);
    vecs[8]  = mk(0, 0, 32'h0,        0, 0, 7, 7, 32'd99, 32'd99, 1, 1);
    vecs[9]  = mk(0, 0, 32'h0,        1, 0, 0, 7, 32'h0, 32'd99, 0, 1);
    vecs[10] = mk(0, 0, 32'h0,        0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 0, 0);

    W = 0; WAd = 0; Data = 0; Rsv = 0; RsvAd = 0; Clr = 0; R1 = 0; R2 = 0;
    s_W = 0; s_WAd = 0; s_Data = 0; s_Rsv = 0; s_RsvAd = 0; s_Clr = 0; s_R1 = 0; s_R2 = 0;
    Rst_n = 1'b0;
    model_reset();
    #12 Rst_n = 1'b1;

    for (int r = 0; r < 32; r++) begin
      R1 = 5'(r); R2 = 5'(31 - r);
      #1;
      cmp("rst.A", A, 32'h0);
      cmp("rst.B", B, 32'h0);
      cmp("rst.busy", {30'h0, A_busy, B_busy}, 32'h0);
      cmp("rst.Ready", 32'(Ready), 32'h1);
      tick();
    end

    for (int i = 0; i < 11; i++) begin
      W = vecs[i].w; WAd = vecs[i].wad; Data = vecs[i].data;
      Rsv = vecs[i].rsv; RsvAd = vecs[i].rsvad; R1 = vecs[i].r1; R2 = vecs[i].r2;
      #1;
      cmp($sformatf("vec%0d.A", i), A, vecs[i].ea);
      cmp($sformatf("vec%0d.B", i), B, vecs[i].eb);
      cmp($sformatf("vec%0d.A_busy", i), 32'(A_busy), 32'(vecs[i].eab));
      cmp($sformatf("vec%0d.B_busy", i), 32'(B_busy), 32'(vecs[i].ebb));
      tick();
    end
    W = 0; Rsv = 0;

    // Full sweep with writes/reserves attempted while it runs
    for (int i = 1; i < 32; i++) begin
      W = 1; WAd = 5'(i); Data = 32'(i);
      tick();
    end
    W = 0; Clr = 1; R1 = 10; R2 = 12;
    #1;
    check_model("pre_clr");
    tick();
    Clr = 0; W = 1; WAd = 10; Data = 32'hFFFF; Rsv = 1; RsvAd = 12;
    for (int j = 0; j < 32; j++) begin
      #1;
      cmp($sformatf("sweep%0d.Ready", j), 32'(Ready), 32'h0);
      cmp($sformatf("sweep%0d.r10", j), A, (j < 11) ? 32'd10 : 32'd0);
      check_model($sformatf("sweep%0d", j));
      tick();
    end
    W = 0; Rsv = 0;
    #1;
    cmp("post_sweep.Ready", 32'(Ready), 32'h1);
    cmp("post_sweep.r10", A, 32'h0);
    cmp("post_sweep.r12_busy", 32'(B_busy), 32'h0);
    check_model("post_sweep");

    // Reset asserted part-way through a sweep
    for (int i = 1; i < 32; i++) begin
      W = 1; WAd = 5'(i); Data = 32'(i * 3 + 1);
      tick();
    end
    W = 0; Clr = 1;
    tick();
    Clr = 0;
    repeat (15) tick();
    Rst_n = 1'b0;
    model_reset();
    #1;
    cmp("midrst.Ready", 32'(Ready), 32'h1);
    for (int r = 0; r < 32; r++) begin
      R1 = 5'(r); R2 = 5'(r);
      #1;
      cmp($sformatf("midrst.r%0d", r), A, 32'h0);
      cmp($sformatf("midrst.busy%0d", r), 32'(B_busy), 32'h0);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    // Random traffic against the model
    repeat (400) begin
      W = 1'($urandom_range(0, 1));
      WAd = 5'($urandom);
      Data = $urandom;
      Rsv = 1'($urandom_range(0, 1));
      RsvAd = 5'($urandom);
      Clr = ($urandom_range(0, 39) == 0);
      R1 = ($urandom_range(0, 3) == 0) ? WAd : 5'($urandom);
      R2 = ($urandom_range(0, 3) == 0) ? RsvAd : 5'($urandom);
      #1;
      check_model("rand");
      tick();
    end
    W = 0; Rsv = 0; Clr = 0;
    n = 0;
    while (m_sweep && n < 40) begin
      tick();
      n++;
    end
    #1;
    check_model("drain");

    // DEPTH=20 instance: out-of-range access and shorter sweep
    s_W = 1; s_WAd = 25; s_Data = 32'hAAAA; s_R1 = 25; s_R2 = 25;
    #1;
    cmp("d20.rd25_bypass", s_A, 32'h0);
    tick();
    s_W = 0;
    #1;
    cmp("d20.rd25", s_A, 32'h0);
    cmp("d20.rd25_busy", 32'(s_B_busy), 32'h0);
    s_W = 1; s_WAd = 19; s_Data = 32'h55; s_R1 = 19;
    #1;
    cmp("d20.rd19_bypass", s_A, 32'h55);
    tick();
    s_W = 0;
    #1;
    cmp("d20.rd19", s_A, 32'h55);
    s_Clr = 1;
    tick();
    s_Clr = 0;
    n = 0;
    while (!s_Ready && n < 100) begin
      tick();
      n++;
    end
    cmp("d20.sweep_len", 32'(n), 32'd20);
    cmp("d20.rd19_cleared", s_A, 32'h0);
    check_model("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
